memory_rd_stream: RTL and testbench

//  Read-side streaming engine for the dual-port memory wrapper (1 read port, 1-cycle read latency).

---
 rtl/memory_rd_stream.sv | 131 +++++++++++++
 tb/tb_memory_rd_stream.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_rd_stream.sv
`default_nettype none
// ============================================================================
// Module  : memory_rd_stream
// Purpose : Block-read streaming engine from a 1-cycle-latency memory read
//           port into an access/wait stream with a 2-entry return buffer.
// Revision: 1.0
// ============================================================================
module memory_rd_stream #(
   parameter int AW = 14,
   parameter int DW = 32,
   parameter int LW = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          cmd_start,
   input  logic [AW-1:0] cmd_addr,
   input  logic [LW-1:0] cmd_count,
   output logic          busy,
   output logic          done,
   output logic          mem_rd_en,
   output logic [AW-1:0] mem_rd_addr,
   input  logic [DW-1:0] mem_rd_data,
   output logic          out_access,
   output logic [DW-1:0] out_data,
   input  logic          out_wait
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t        state;
   state_t        state_nxt;
   logic [AW-1:0] addr;
   logic [LW-1:0] remaining;
   logic          inflight;
   logic [1:0]    occ;
   logic [DW-1:0] fifo [2];
   logic          rd_ptr;
   logic          wr_ptr;
   logic          done_r;
   logic          done_nxt;
   logic          pop;
   logic          issue;
   logic          accept;
   logic [2:0]    pending;

   assign out_access  = (occ != 2'd0);
   assign out_data    = fifo[rd_ptr];
   assign pop         = out_access & ~out_wait;
   assign busy        = (state != S_IDLE);
   assign done        = done_r;
   assign mem_rd_en   = issue;
   assign mem_rd_addr = addr;
   assign accept      = (state == S_IDLE) && cmd_start && (cmd_count != '0);

   // Words that will be held or arriving after this cycle, before any new issue
   assign pending = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
   assign issue   = (state == S_READ) && (remaining != '0) && (pending < 3'd2);

   always_comb begin
      state_nxt = state;
      done_nxt  = 1'b0;
      case (state)
         S_IDLE: begin
            if (accept) begin
               state_nxt = S_READ;
            end else if (cmd_start) begin
               done_nxt = 1'b1;
            end
         end
         S_READ: begin
            if (issue && (remaining == LW'(1))) begin
               state_nxt = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (pending == 3'd0) begin
               state_nxt = S_IDLE;
               done_nxt  = 1'b1;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= S_IDLE;
         done_r    <= 1'b0;
         addr      <= '0;
         remaining <= '0;
         inflight  <= 1'b0;
      end else begin
         state    <= state_nxt;
         done_r   <= done_nxt;
         inflight <= issue;
         if (accept) begin
            addr      <= cmd_addr;
            remaining <= cmd_count;
         end else if (issue) begin
            addr      <= addr + AW'(1);
            remaining <= remaining - LW'(1);
         end
      end
   end

   // Return buffer: the word read last cycle lands at the tail
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fifo[0] <= '0;
         fifo[1] <= '0;
         rd_ptr  <= 1'b0;
         wr_ptr  <= 1'b0;
         occ     <= 2'd0;
      end else begin
         if (inflight) begin
            fifo[wr_ptr] <= mem_rd_data;
            wr_ptr       <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         occ <= occ + {1'b0, inflight} - {1'b0, pop};
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_memory_rd_stream.sv
`default_nettype none
// ============================================================================
// Module  : tb_memory_rd_stream
// Purpose : Self-checking bench: memory model, expected address/data queues,
//           per-cycle stream compare and literal timing checks.
// Revision: 1.0
// ============================================================================
module tb_memory_rd_stream;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        cmd_start = 1'b0;
   logic [13:0] cmd_addr = '0;
   logic [15:0] cmd_count = '0;
   logic        busy, done, mem_rd_en, out_access;
   logic [13:0] mem_rd_addr;
   logic [31:0] mem_rd_data = '0;
   logic [31:0] out_data;
   logic        out_wait = 1'b0;

   memory_rd_stream #(.AW(14), .DW(32), .LW(16)) dut (
      .clk(clk), .reset(reset), .cmd_start(cmd_start), .cmd_addr(cmd_addr),
      .cmd_count(cmd_count), .busy(busy), .done(done), .mem_rd_en(mem_rd_en),
      .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
      .out_access(out_access), .out_data(out_data), .out_wait(out_wait)
   );

   always #5 clk = ~clk;

   logic [31:0] mem [0:16383];
   always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];

   int cyc = 0;
   always @(posedge clk) cyc++;

   int vecs = 0;
   int errs = 0;
   int wait_mode = 0;
   int first_rd, last_rd, rd_cnt, first_out, last_out, pop_cnt, done_cyc, done_cnt;
   bit busy_seen;
   logic [13:0] addr_log [$];
   logic [13:0] addr_q [$];
   logic [31:0] data_q [$];
   logic        prev_stall = 1'b0;
   logic [31:0] prev_data = '0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic fail(input string nm);
      vecs++;
      errs++;
      $display("FAIL %s (cycle %0d)", nm, cyc);
   endtask

   // Per-cycle compare against the expected address and data streams
   always @(negedge clk) begin
      if (reset) begin
         prev_stall = 1'b0;
      end else begin
         if (busy) busy_seen = 1'b1;
         if (mem_rd_en) begin
            if (rd_cnt == 0) first_rd = cyc;
            last_rd = cyc;
            rd_cnt++;
            addr_log.push_back(mem_rd_addr);
            if (addr_q.size() == 0) fail("unexpected_read");
            else chk("rd_addr", mem_rd_addr, addr_q.pop_front());
         end
         if (prev_stall) begin
            chk("stall_access", out_access, 1);
            chk("stall_data", out_data, prev_data);
         end
         if (out_access && !out_wait) begin
            if (pop_cnt == 0) first_out = cyc;
            last_out = cyc;
            pop_cnt++;
            if (data_q.size() == 0) fail("unexpected_word");
            else chk("out_data", out_data, data_q.pop_front());
         end
         if (mem_rd_en) chk("outstanding_le2", (rd_cnt - pop_cnt) <= 2, 1);
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
            chk("done_busy_low", busy, 0);
            chk("done_drained", data_q.size(), 0);
         end
         prev_stall = out_access && out_wait;
         prev_data  = out_data;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
      cmd_start = 1'b0;
      case (wait_mode)
         0:       out_wait = 1'b0;
         1:       out_wait = 1'($urandom_range(0, 1));
         default: out_wait = 1'b1;
      endcase
   endtask

   // Called right after a clock edge; the current cycle becomes t
   task automatic start_cmd(input logic [13:0] a, input logic [15:0] n, input bit accept, output int t);
      t = cyc;
      cmd_start = 1'b1;
      cmd_addr  = a;
      cmd_count = n;
      if (accept) begin
         rd_cnt = 0; pop_cnt = 0; busy_seen = 1'b0;
         first_rd = -1; last_rd = -1; first_out = -1; last_out = -1; done_cyc = -1;
         addr_log.delete();
         for (int i = 0; i < int'(n); i++) begin
            addr_q.push_back(a + 14'(i));
            data_q.push_back(mem[a + 14'(i)]);
         end
      end
   endtask

   task automatic wait_done(input int budget, input string nm);
      int dc0 = done_cnt;
      int k = 0;
      while (done_cnt == dc0 && k < budget) begin
         step();
         k++;
      end
      if (done_cnt == dc0) fail({nm, "_done_timeout"});
      step();
   endtask

   task automatic chk_zero(input string nm);
      chk({nm, "_busy"}, busy, 0);
      chk({nm, "_done"}, done, 0);
      chk({nm, "_rd_en"}, mem_rd_en, 0);
      chk({nm, "_rd_addr"}, mem_rd_addr, 0);
      chk({nm, "_access"}, out_access, 0);
      chk({nm, "_data"}, out_data, 0);
   endtask

   initial begin
      int t;
      int dc;
      int k;
      logic [13:0] ra;
      for (int i = 0; i < 16384; i++) mem[i] = $urandom;
      for (int i = 0; i < 4; i++) mem[16 + i] = 32'hA0A0_0000 + i;
      done_cnt = 0; rd_cnt = 0; pop_cnt = 0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_zero("reset");
      step();
      reset = 1'b0;
      step();

      // 1: basic timing, no backpressure
      wait_mode = 0;
      start_cmd(14'h0010, 16'd4, 1, t);
      wait_done(50, "t1");
      chk("t1_first_rd", first_rd, t + 1);
      chk("t1_last_rd", last_rd, t + 4);
      chk("t1_first_out", first_out, t + 3);
      chk("t1_last_out", last_out, t + 6);
      chk("t1_done_cyc", done_cyc, t + 7);
      chk("t1_pops", pop_cnt, 4);

      // 2: consumer stall t+2..t+10
      start_cmd(14'h0010, 16'd4, 1, t);
      step();
      wait_mode = 2;
      while (cyc < t + 10) step();
      @(negedge clk);
      chk("t2_reads_in_stall", rd_cnt, 2);
      chk("t2_access_hold", out_access, 1);
      chk("t2_data_hold", out_data, 32'hA0A0_0000);
      wait_mode = 0;
      wait_done(50, "t2");
      chk("t2_pops", pop_cnt, 4);

      // 3: long random-backpressure stream
      wait_mode = 1;
      ra = 14'($urandom);
      start_cmd(ra, 16'd1000, 1, t);
      wait_done(6000, "t3");
      chk("t3_pops", pop_cnt, 1000);
      chk("t3_done_after_last", done_cyc, last_out + 1);

      // 4: address wrap
      start_cmd(14'h3FFE, 16'd4, 1, t);
      wait_done(100, "t4");
      chk("t4_addr0", addr_log.size() > 0 ? addr_log[0] : 14'h1, 14'h3FFE);
      chk("t4_addr1", addr_log.size() > 1 ? addr_log[1] : 14'h1, 14'h3FFF);
      chk("t4_addr2", addr_log.size() > 2 ? addr_log[2] : 14'h1, 14'h0000);
      chk("t4_addr3", addr_log.size() > 3 ? addr_log[3] : 14'h0, 14'h0001);
      chk("t4_done_after_last", done_cyc, last_out + 1);

      // 5: zero count, then start while busy
      wait_mode = 0;
      start_cmd(14'h0123, 16'd0, 1, t);
      wait_done(10, "t5a");
      chk("t5_zero_done_cyc", done_cyc, t + 1);
      chk("t5_zero_reads", rd_cnt, 0);
      chk("t5_zero_busy", busy_seen, 0);
      wait_mode = 1;
      start_cmd(14'h0200, 16'd6, 1, t);
      step();
      step();
      start_cmd(14'h3000, 16'd5, 0, t);
      wait_done(100, "t5b");
      chk("t5_busy_pops", pop_cnt, 6);
      chk("t5_busy_reads", rd_cnt, 6);

      // 6: reset while the 3rd word of an 8-word command is presented
      wait_mode = 0;
      start_cmd(14'h0400, 16'd8, 1, t);
      k = 0;
      while (pop_cnt < 2 && k < 30) begin
         step();
         k++;
      end
      if (pop_cnt < 2) fail("t6_third_word_timeout");
      dc = done_cnt;
      reset = 1'b1;
      #1;
      chk_zero("t6_reset");
      addr_q.delete();
      data_q.delete();
      step();
      step();
      reset = 1'b0;
      step();
      step();
      chk("t6_no_done", done_cnt, dc);
      start_cmd(14'h0500, 16'd2, 1, t);
      wait_done(50, "t6");
      chk("t6_pops", pop_cnt, 2);
      chk("t6_reads", rd_cnt, 2);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
`default_nettype wire
